// File: rtl/engine_pkg.sv
// Shared engine definitions: DMA port count, command encodings, address
// width and the arbiter state encoding.
package engine_pkg;

    localparam int DMA_PORTS  = 6;
    localparam int DMA_ADDR_W = 30;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_XFER  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    // One-hot port vector for a port index.
    function automatic logic [DMA_PORTS-1:0] port_onehot(input logic [2:0] idx);
        port_onehot = {{(DMA_PORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin successor of a port index, wrapping 5 -> 0.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        next_ptr = (idx == 3'(DMA_PORTS - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin priority encoder for the six DMA ports:
// returns the first requesting port at or above ptr, wrapping modulo 6.
module rr_pick6
    import engine_pkg::*;
(
    input  logic [DMA_PORTS-1:0] req,
    input  logic [2:0]           ptr,
    output logic [2:0]           idx,
    output logic                 found
);

    // Scan from the far end back toward ptr so the nearest requester wins.
    always_comb begin
        logic [3:0] sum;
        logic [2:0] cand;
        idx   = 3'd0;
        found = 1'b0;
        sum   = 4'd0;
        cand  = 3'd0;
        for (int k = DMA_PORTS - 1; k >= 0; k--) begin
            sum  = {1'b0, ptr} + 4'(k);
            cand = (sum >= 4'(DMA_PORTS)) ? 3'(sum - 4'(DMA_PORTS)) : sum[2:0];
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_port_arbiter.sv
// Shares the memory-controller command channel among the six DMA ports.
// Each grant issues one fixed-length burst; ports are served round-robin.
// No data path: beats flow directly between engine FIFOs and the controller.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | no burst owned; pick next requester from rr_ptr
//   ST_GRANT | grant and command fields driven; strobe prepared for ISSUE
//   ST_ISSUE | mem_cmd_en strobes once the command FIFO has room
//   ST_XFER  | counting beats until the burst is complete
//   ST_DONE  | port_done pulse, advance rr_ptr, release the grant
module dma_port_arbiter
    import engine_pkg::*;
#(
    parameter int                   BURST_LEN  = 16,
    parameter int                   ADDR_W     = DMA_ADDR_W,
    parameter logic [DMA_PORTS-1:0] WRITE_MASK = 6'b000011
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DMA_PORTS-1:0]        port_req,
    input  logic [DMA_PORTS*ADDR_W-1:0] port_addr,
    output logic [DMA_PORTS-1:0]        port_grant,
    output logic [DMA_PORTS-1:0]        port_done,
    output logic                        mem_cmd_en,
    output logic [2:0]                  mem_cmd_instr,
    output logic [ADDR_W-1:0]           mem_cmd_addr,
    output logic [5:0]                  mem_cmd_bl,
    input  logic                        mem_cmd_full,
    input  logic                        mem_beat,
    output logic                        busy
);

    localparam logic [6:0] LAST_BEAT = 7'(BURST_LEN - 1);
    localparam logic [6:0] FULL_CNT  = 7'(BURST_LEN);

    arb_state_t        state;
    logic [2:0]        rr_ptr;
    logic [2:0]        grant_idx;
    logic [6:0]        beat_cnt;
    logic [2:0]        pick_idx;
    logic              pick_found;
    logic [ADDR_W-1:0] addr_slot [DMA_PORTS];

    assign mem_cmd_bl = 6'(BURST_LEN - 1);

    for (genvar g = 0; g < DMA_PORTS; g++) begin : g_addr_slot
        assign addr_slot[g] = port_addr[g*ADDR_W +: ADDR_W];
    end

    rr_pick6 u_pick (
        .req   (port_req),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Burst sequencer. mem_cmd_en is registered, so the strobe is prepared one
    // cycle ahead from the mem_cmd_full level seen in GRANT/ISSUE; ISSUE exits
    // on the cycle the strobe is actually high. Early write beats seen in ISSUE
    // count toward the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= 3'd0;
            grant_idx     <= 3'd0;
            beat_cnt      <= 7'd0;
            port_grant    <= '0;
            port_done     <= '0;
            mem_cmd_en    <= 1'b0;
            mem_cmd_instr <= CMD_WRITE;
            mem_cmd_addr  <= '0;
            busy          <= 1'b0;
        end else begin
            mem_cmd_en <= 1'b0;
            port_done  <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_idx     <= pick_idx;
                        mem_cmd_addr  <= addr_slot[pick_idx];
                        mem_cmd_instr <= WRITE_MASK[pick_idx] ? CMD_WRITE : CMD_READ;
                        port_grant    <= port_onehot(pick_idx);
                        busy          <= 1'b1;
                        state         <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    mem_cmd_en <= ~mem_cmd_full;
                    state      <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (mem_beat && beat_cnt < FULL_CNT) begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                    if (mem_cmd_en) begin
                        state <= ST_XFER;
                    end else begin
                        mem_cmd_en <= ~mem_cmd_full;
                    end
                end
                ST_XFER: begin
                    // A burst whose beats all arrived early finishes without more beats.
                    if (beat_cnt == FULL_CNT || (mem_beat && beat_cnt == LAST_BEAT)) begin
                        port_done <= port_grant;
                        state     <= ST_DONE;
                    end
                    if (mem_beat && beat_cnt < FULL_CNT) begin
                        beat_cnt <= beat_cnt + 7'd1;
                    end
                end
                ST_DONE: begin
                    beat_cnt   <= 7'd0;
                    rr_ptr     <= next_ptr(grant_idx);
                    port_grant <= '0;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
